// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access; data has priority,
// bounded by a streak limit. Define ARB_PERF_CNT_EN to add the perf_if_wait stall counter.
module mem_port_arbiter #(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_if_wait
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t        state_q, state_d;
  logic [3:0]    streak_q, streak_d;
  logic          owner_dm_q, owner_dm_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          if_rvalid_d, dm_rvalid_d;
  logic [DW-1:0] if_rdata_d, dm_rdata_d;
  logic          dm_wins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rvalid  <= if_rvalid_d;
      dm_rvalid  <= dm_rvalid_d;
      if_rdata   <= if_rdata_d;
      dm_rdata   <= dm_rdata_d;
    end
  end

  // Data yields only when fetch is waiting and the data streak has hit its limit.
  assign dm_wins = dm_req && !(if_req && (streak_q == STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!if_req) streak_d = '0;
        if (rst_n && dm_wins) begin
          dm_gnt     = 1'b1;
          owner_dm_d = 1'b1;
          we_d       = dm_we;
          addr_d     = dm_addr;
          wdata_d    = dm_wdata;
          if (if_req && (streak_q != STREAK_MAX)) streak_d = streak_q + 4'd1;
          state_d    = REQ;
        end else if (rst_n && if_req) begin
          if_gnt     = 1'b1;
          owner_dm_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_addr;
          wdata_d    = '0;
          streak_d   = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = '0;
            state_d     = IDLE;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = (state_q == REQ) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_wait <= '0;
    end else if (if_req && !if_gnt) begin
      perf_if_wait <= perf_if_wait + 32'd1;
    end
  end
`endif

endmodule
